// File: rtl/win3x3_pkg.sv
// Shared constants, tap indices and FSM state type for the 3x3 window generator.
package win3x3_pkg;
  localparam int PIX_W     = 8;
  localparam int WIN_TAPS  = 9;
  localparam int IMG_W_DEF = 8;
  localparam int IMG_H_DEF = 8;

  localparam int TAP_TL = 0;
  localparam int TAP_T  = 1;
  localparam int TAP_TR = 2;
  localparam int TAP_L  = 3;
  localparam int TAP_C  = 4;
  localparam int TAP_R  = 5;
  localparam int TAP_BL = 6;
  localparam int TAP_B  = 7;
  localparam int TAP_BR = 8;

  typedef enum logic [1:0] {ST_FILL, ST_STREAM, ST_FLUSH} state_t;
endpackage

// File: rtl/win3x3_linebuf.sv
// Pixel delay line of 2*IMG_W+3 entries; entry 0 is the newest pixel.
// Exposes the nine raw window taps for the centre IMG_W+1 pixels behind the newest.
module win3x3_linebuf
  import win3x3_pkg::*;
#(
  parameter int IMG_W = IMG_W_DEF
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic                      i_shift,
  input  logic [PIX_W-1:0]          i_pixel,
  output logic [WIN_TAPS*PIX_W-1:0] o_taps
);
  localparam int DEPTH = 2 * IMG_W + 3;

  logic [PIX_W-1:0] r_sr [DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int j = 0; j < DEPTH; j++) r_sr[j] <= '0;
    end else if (i_shift) begin
      r_sr[0] <= i_pixel;
      for (int j = 1; j < DEPTH; j++) r_sr[j] <= r_sr[j-1];
    end
  end

  assign o_taps[TAP_TL*PIX_W +: PIX_W] = r_sr[2*IMG_W+2];
  assign o_taps[TAP_T *PIX_W +: PIX_W] = r_sr[2*IMG_W+1];
  assign o_taps[TAP_TR*PIX_W +: PIX_W] = r_sr[2*IMG_W];
  assign o_taps[TAP_L *PIX_W +: PIX_W] = r_sr[IMG_W+2];
  assign o_taps[TAP_C *PIX_W +: PIX_W] = r_sr[IMG_W+1];
  assign o_taps[TAP_R *PIX_W +: PIX_W] = r_sr[IMG_W];
  assign o_taps[TAP_BL*PIX_W +: PIX_W] = r_sr[2];
  assign o_taps[TAP_B *PIX_W +: PIX_W] = r_sr[1];
  assign o_taps[TAP_BR*PIX_W +: PIX_W] = r_sr[0];
endmodule

// File: rtl/win3x3_gen.sv
// Raster 3x3 window generator: one window per pixel, latency IMG_W+1 accepted pixels.
// Edge taps are zero-padded, or edge-replicated when WIN_REPLICATE_EN is defined.
module win3x3_gen
  import win3x3_pkg::*;
#(
  parameter int IMG_W = IMG_W_DEF,
  parameter int IMG_H = IMG_H_DEF
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic                      i_valid,
  input  logic [PIX_W-1:0]          i_pixel,
  output logic                      o_ready,
  output logic                      o_valid,
  output logic [WIN_TAPS*PIX_W-1:0] o_win,
  output logic                      o_last
);
  localparam int CNT_W = $clog2(IMG_W * IMG_H);
  localparam int ROW_W = $clog2(IMG_H);
  localparam int COL_W = $clog2(IMG_W);

  state_t                      r_state, w_state_nxt;
  logic [CNT_W-1:0]            r_cnt, w_cnt_nxt;
  logic [ROW_W-1:0]            r_nrow, r_orow;
  logic [COL_W-1:0]            r_ncol, r_ocol;
  logic                        r_valid, r_last;
  logic                        w_accept, w_shift, w_emit;
  logic [WIN_TAPS*PIX_W-1:0]   w_taps, w_win;
  logic                        w_row_top, w_row_bot, w_col_lft, w_col_rgt;

  assign o_ready  = (r_state != ST_FLUSH);
  assign w_accept = i_valid & o_ready;
  assign w_shift  = w_accept | (r_state == ST_FLUSH);
  assign w_emit   = ((r_state == ST_STREAM) & w_accept) | (r_state == ST_FLUSH);

  // r_cnt counts accepted pixels in FILL/STREAM and drain cycles in FLUSH.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      ST_FILL: if (w_accept) begin
        w_cnt_nxt = r_cnt + 1'b1;
        if (r_cnt == CNT_W'(IMG_W)) w_state_nxt = ST_STREAM;
      end
      ST_STREAM: if (w_accept) begin
        w_cnt_nxt = r_cnt + 1'b1;
        if (r_cnt == CNT_W'(IMG_W * IMG_H - 1)) begin
          w_state_nxt = ST_FLUSH;
          w_cnt_nxt   = '0;
        end
      end
      ST_FLUSH: begin
        w_cnt_nxt = r_cnt + 1'b1;
        if (r_cnt == CNT_W'(IMG_W)) begin
          w_state_nxt = ST_FILL;
          w_cnt_nxt   = '0;
        end
      end
      default: begin
        w_state_nxt = ST_FILL;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= ST_FILL;
      r_cnt   <= '0;
      r_nrow  <= '0;
      r_ncol  <= '0;
      r_orow  <= '0;
      r_ocol  <= '0;
      r_valid <= 1'b0;
      r_last  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_valid <= w_emit;
      r_last  <= w_emit & (r_nrow == ROW_W'(IMG_H - 1)) & (r_ncol == COL_W'(IMG_W - 1));
      if (w_emit) begin
        r_orow <= r_nrow;
        r_ocol <= r_ncol;
        if (r_ncol == COL_W'(IMG_W - 1)) begin
          r_ncol <= '0;
          r_nrow <= (r_nrow == ROW_W'(IMG_H - 1)) ? '0 : r_nrow + 1'b1;
        end else begin
          r_ncol <= r_ncol + 1'b1;
        end
      end
    end
  end

  win3x3_linebuf #(.IMG_W(IMG_W)) u_linebuf (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_shift (w_shift),
    .i_pixel (w_accept ? i_pixel : '0),
    .o_taps  (w_taps)
  );

  assign w_row_top = (r_orow == '0);
  assign w_row_bot = (r_orow == ROW_W'(IMG_H - 1));
  assign w_col_lft = (r_ocol == '0);
  assign w_col_rgt = (r_ocol == COL_W'(IMG_W - 1));

  for (genvar t = 0; t < WIN_TAPS; t++) begin : g_tap
    localparam int DR = t / 3 - 1;
    localparam int DC = t % 3 - 1;
    logic w_rin, w_cin;
    assign w_rin = (DR < 0) ? !w_row_top : (DR > 0) ? !w_row_bot : 1'b1;
    assign w_cin = (DC < 0) ? !w_col_lft : (DC > 0) ? !w_col_rgt : 1'b1;
`ifdef WIN_REPLICATE_EN
    // Clamp row and column independently back towards the centre tap.
    logic [1:0] w_sr, w_sc;
    logic [3:0] w_src;
    assign w_sr  = w_rin ? 2'(DR + 1) : 2'd1;
    assign w_sc  = w_cin ? 2'(DC + 1) : 2'd1;
    assign w_src = {2'b00, w_sr} * 4'd3 + {2'b00, w_sc};
    assign w_win[t*PIX_W +: PIX_W] = w_taps[w_src*PIX_W +: PIX_W];
`else
    assign w_win[t*PIX_W +: PIX_W] = (w_rin & w_cin) ? w_taps[t*PIX_W +: PIX_W] : '0;
`endif
  end

  assign o_valid = r_valid;
  assign o_last  = r_last;
  assign o_win   = r_valid ? w_win : '0;
endmodule

// File: tb/tb_win3x3_gen.sv
// Directed bench for win3x3_gen at 8x8 with pixel value = index+1; define WIN_REPLICATE_EN
// for both bench and RTL to check the edge-replicate build.
module tb_win3x3_gen;
  localparam int W = 8;
  localparam int H = 8;
  localparam int N = W * H;

  logic        clk;
  logic        i_rst, i_valid;
  logic [7:0]  i_pixel;
  logic        o_ready, o_valid, o_last;
  logic [71:0] o_win;

  int checks = 0;
  int errors = 0;

  // bench-side model state
  int n_acc, fl, k, wcnt;
  bit exp_rdy;

  win3x3_gen #(.IMG_W(W), .IMG_H(H)) dut (
    .i_clk   (clk),
    .i_rst   (i_rst),
    .i_valid (i_valid),
    .i_pixel (i_pixel),
    .o_ready (o_ready),
    .o_valid (o_valid),
    .o_win   (o_win),
    .o_last  (o_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hand-computed windows, w8 in the top byte.
`ifdef WIN_REPLICATE_EN
  localparam logic [71:0] HAND_FIRST = {8'd10, 8'd9, 8'd9, 8'd2, 8'd1, 8'd1, 8'd2, 8'd1, 8'd1};
  localparam logic [71:0] HAND_LAST  = {8'd64, 8'd64, 8'd63, 8'd64, 8'd64, 8'd63, 8'd56, 8'd56, 8'd55};
`else
  localparam logic [71:0] HAND_FIRST = {8'd10, 8'd9, 8'd0, 8'd2, 8'd1, 8'd0, 8'd0, 8'd0, 8'd0};
  localparam logic [71:0] HAND_LAST  = {8'd0, 8'd0, 8'd0, 8'd0, 8'd64, 8'd63, 8'd0, 8'd56, 8'd55};
`endif
  localparam logic [71:0] HAND_MID = {8'd38, 8'd37, 8'd36, 8'd30, 8'd29, 8'd28, 8'd22, 8'd21, 8'd20};

  function automatic logic [71:0] exp_win(input int kk);
    logic [71:0] w;
    int r, c, rr, cc;
    w = '0;
    r = kk / W;
    c = kk % W;
    for (int t = 0; t < 9; t++) begin
      rr = r + t / 3 - 1;
      cc = c + t % 3 - 1;
`ifdef WIN_REPLICATE_EN
      if (rr < 0) rr = 0;
      if (rr > H - 1) rr = H - 1;
      if (cc < 0) cc = 0;
      if (cc > W - 1) cc = W - 1;
      w[t*8 +: 8] = 8'(rr * W + cc + 1);
`else
      if (rr >= 0 && rr < H && cc >= 0 && cc < W) w[t*8 +: 8] = 8'(rr * W + cc + 1);
`endif
    end
    return w;
  endfunction

  task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    n_acc   = 0;
    fl      = 0;
    k       = 0;
    exp_rdy = 1'b1;
  endtask

  // One clock: drive, check ready, advance, check emitted window against the model.
  task automatic cyc(input bit v, input logic [7:0] p);
    bit acc, inflush, emit;
    i_valid = v;
    i_pixel = p;
    chk("ready", {71'd0, o_ready}, {71'd0, exp_rdy});
    acc     = v && exp_rdy;
    inflush = (fl > 0);
    @(posedge clk); #1;
    emit = (acc && n_acc >= W + 1) || inflush;
    if (inflush) fl--;
    if (acc) begin
      n_acc++;
      if (n_acc == N) begin
        n_acc = 0;
        fl    = W + 1;
      end
    end
    exp_rdy = (fl == 0);
    chk("valid", {71'd0, o_valid}, {71'd0, emit});
    chk("last", {71'd0, o_last}, {71'd0, emit && k == N - 1});
    if (emit) begin
      chk($sformatf("win_k%0d", k), o_win, exp_win(k));
      if (k == 0)      chk("hand_first", o_win, HAND_FIRST);
      if (k == 28)     chk("hand_mid", o_win, HAND_MID);
      if (k == N - 1)  chk("hand_last", o_win, HAND_LAST);
      k = (k + 1) % N;
      wcnt++;
    end
  endtask

  task automatic do_reset();
    i_rst   = 1'b1;
    i_valid = 1'b1;
    i_pixel = 8'hAA;
    @(posedge clk); #1;
    i_rst   = 1'b0;
    i_valid = 1'b0;
    model_reset();
    chk("rst_valid", {71'd0, o_valid}, 72'd0);
    chk("rst_last", {71'd0, o_last}, 72'd0);
    chk("rst_win", o_win, 72'd0);
    chk("rst_ready", {71'd0, o_ready}, 72'd1);
  endtask

  task automatic run_frame(input bit gaps, input int budget);
    int start, guard;
    start = wcnt;
    guard = 0;
    while (wcnt < start + N && guard < budget) begin
      if (fl > 0)
        cyc(1'b1, gaps ? 8'hEE : 8'h00);
      else if (gaps && $urandom_range(0, 2) == 0)
        cyc(1'b0, 8'($urandom_range(0, 255)));
      else
        cyc(1'b1, 8'(n_acc + 1));
      guard++;
    end
    chk("frame_windows", 72'(wcnt - start), 72'(N));
  endtask

  initial begin
    i_rst   = 1'b1;
    i_valid = 1'b0;
    i_pixel = 8'h00;
    wcnt    = 0;
    model_reset();
    @(posedge clk); #1;
    do_reset();

    // contiguous frame, then a few idle cycles
    run_frame(1'b0, 200);
    for (int i = 0; i < 3; i++) cyc(1'b0, 8'h00);

    // random input gaps; valid held high during the flush
    run_frame(1'b1, 600);
    cyc(1'b0, 8'h00);

    // reset after 30 pixels; partial frame must leave no trace
    for (int i = 0; i < 30; i++) cyc(1'b1, 8'(n_acc + 1));
    do_reset();
    for (int i = 0; i < 4; i++) cyc(1'b0, 8'h00);
    run_frame(1'b0, 200);

    // reset in the middle of a flush, then a clean frame
    for (int i = 0; i < N + 3; i++) cyc(1'b1, 8'(n_acc + 1));
    do_reset();
    run_frame(1'b0, 200);
    cyc(1'b0, 8'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/win3x3_gen.md
WIN3X3_GEN -- requirements
Module: win3x3_gen

Interface
REQ-001 SHALL have parameter IMG_W, default 8: image width in pixels, minimum 3.
REQ-002 SHALL have parameter IMG_H, default 8: image height in pixels, minimum 3.
REQ-003 SHALL have port i_clk, input, 1: the single clock; all logic rising-edge.
REQ-004 SHALL have port i_rst, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port i_valid, input, 1: i_pixel valid this cycle.
REQ-006 SHALL have port i_pixel, input, 8: raster-order pixel, unsigned.
REQ-007 SHALL have port o_ready, output, 1: a pixel is accepted only when i_valid and o_ready are both 1.
REQ-008 SHALL have port o_valid, output, 1: o_win holds one window this cycle; there is no downstream backpressure.
REQ-009 SHALL have port o_win, output, 72: taps w0..w8, row-major from top-left; wN is at bits [8N+7:8N]; w4 is the centre.
REQ-010 SHALL have port o_last, output, 1: high with o_valid for the window centred on (IMG_H-1, IMG_W-1).

Function
REQ-011 SHALL emit exactly one window per image pixel, in raster order of centre position.
REQ-012 SHALL use a fixed latency: the window for centre index k (k = row*IMG_W + col) has o_valid high in the cycle after pixel k+IMG_W+1 is accepted.
REQ-013 SHALL fill out-of-image taps (row -1, row IMG_H, col -1, col IMG_W) with 0; in-image taps carry the accepted pixel values.
REQ-014 SHALL implement the FSM FILL -> STREAM -> FLUSH -> FILL.
- FILL: the first IMG_W+1 pixels of a frame; no output.
- STREAM: one output per accepted pixel, in the cycle after acceptance.
- FLUSH: entered the cycle after the last pixel (index IMG_W*IMG_H-1) is accepted.
REQ-015 SHALL hold o_ready 1 in FILL and STREAM, and 0 for the entire FLUSH state.
REQ-016 SHALL, in FLUSH, emit the remaining IMG_W+1 windows on consecutive cycles, then return to FILL with the frame counter at 0.
REQ-017 SHALL ignore i_valid while o_ready is 0; no pixel is stored or counted.
REQ-018 SHALL hold o_valid 0 and hold all state when i_valid is 0 in FILL or STREAM, so gaps in input delay output without corrupting it.
REQ-019 SHALL wrap from column IMG_W-1 to column 0 of the next row, with no extra cycle at the row boundary.
REQ-020 SHALL accept a new frame from the first FILL cycle after FLUSH, with no dead cycles beyond FLUSH.

Reset
REQ-021 SHALL, on i_rst, enter FILL, clear all counters and line storage, and drive o_valid=0, o_last=0, o_win=0, o_ready=1 from the next cycle.
REQ-022 SHALL discard any partial frame on reset mid-frame or mid-FLUSH; the next accepted pixel is index 0 of a new frame.

Configuration
REQ-023 SHALL support the macro WIN_REPLICATE_EN.
- Defined: each out-of-image tap takes the value of the nearest in-image tap, clamping row and column independently.
- Undefined: zero padding per REQ-013.
- Latency and handshake are identical in both builds.

Structure
REQ-024 SHALL place the following in package win3x3_pkg: PIX_W=8, WIN_TAPS=9, default IMG_W/IMG_H, tap index constants (TAP_C=4), and the FSM state typedef.
REQ-025 SHALL implement pixel storage in one sub-module, win3x3_linebuf: a 2*IMG_W+3-deep, 8-bit shift register advanced on each accepted pixel or FLUSH cycle, exposing the nine tap positions.

Verification
REQ-026 Test scenarios, all at IMG_W=IMG_H=8, frame pixel value = index+1 (values 1..64):
- (a) Zero-pad build; contiguous frame -> first o_valid the cycle after value 10 is accepted, w0..w8 = 0,0,0,0,1,2,0,9,10.
- (b) Same frame -> centre (3,4) window = 20,21,22,28,29,30,36,37,38.
- (c) Same frame -> after value 64 is accepted, o_ready=0 for 9 cycles and 9 more windows follow. The final window has o_last=1 and taps 55,56,0,63,64,0,0,0,0. o_ready returns to 1 the cycle after the last flush emission.
- (d) WIN_REPLICATE_EN build, same frame -> last window = 55,56,56,63,64,64,63,64,64; first window = 1,1,2,1,1,2,9,9,10.
- (e) Random i_valid gaps, plus i_valid held high during FLUSH -> window sequence identical to (a)-(c); pixels offered during FLUSH are not consumed.
- (f) i_rst asserted after 30 pixels, then a full frame -> no output from the discarded pixels; the new frame matches (a)-(c) exactly.
